mult_add_sched: RTL and testbench
=================================

# mult_add_sched

Round-robin scheduler that time-shares one pipelined multiply-accumulate resource (altmult_add-class, fixed latency, accumulator with synchronous load) among NUM_REQ requesters. Each requester submits a burst of operand pairs; the scheduler locks the resource to that requester for the whole burst, drives accumulator load on the first beat, and routes the final accumulated result back to the owner. It sits between the requesting datapath blocks and a single shared multiply-add instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH_A, 16, operand A width
- WIDTH_B, 16, operand B width
- WIDTH_RESULT, 40, accumulator/result width
- LATENCY, 3, cycles from mult_valid to the matching mult_result (>=1)
- TIMEOUT, 64, idle-beat limit for a locked burst (only with MULT_ADD_SCHED_TIMEOUT_EN)
- clock0  in  1  single clock, rising edge
- sclr_n  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  beat is last of burst
- req_dataa  in  NUM_REQ*WIDTH_A  packed operand A, requester i at [i*WIDTH_A +: WIDTH_A]
- req_datab  in  NUM_REQ*WIDTH_B  packed operand B
- req_ready  out  NUM_REQ  one-hot-or-zero beat accept
- mult_dataa  out  WIDTH_A  registered operand A to resource
- mult_datab  out  WIDTH_B  registered operand B to resource
- mult_valid  out  1  resource enable/beat valid
- mult_accum_sload  out  1  load product instead of accumulating (first beat)
- mult_result  in  WIDTH_RESULT  resource accumulator output
- rsp_valid  out  NUM_REQ  one-hot one-cycle result strobe
- rsp_result  out  WIDTH_RESULT  result for strobed requester
- busy  out  1  burst locked or any beat in flight
- timeout_err  out  1  one-cycle pulse on forced burst release

## Operation
- Beat accepted when req_valid[i] && req_ready[i]. req_ready is combinational from req_valid and state.
- States: IDLE, LOCKED. Reset -> IDLE, rr pointer = 0.
- IDLE: grant = first i with req_valid[i], searching from pointer upward with wrap. Only granted requester sees req_ready. Accepted beat issues with mult_accum_sload=1. If req_last also set: stay IDLE, pointer = grant+1 (mod NUM_REQ). Else -> LOCKED, owner = grant.
- LOCKED: req_ready = req_valid[owner] only; all others 0. Owner may leave gaps (valid low); no beat issued in gap. Accepted beats issue with mult_accum_sload=0. Beat with req_last -> IDLE, pointer = owner+1.
- Issue: on acceptance in cycle t, mult_dataa/datab/accum_sload registered, mult_valid=1 in cycle t+1; else mult_valid=0, operands hold.
- Tag pipe: LATENCY+1 stages of {valid, last, id} aligned with mult_valid. When tag at output is valid&&last, rsp_result <= mult_result and rsp_valid[id] <= 1 for one cycle. Non-last beats produce no response.
- Reset values: req_ready (combinational) 0 during reset, mult_* 0, rsp_valid 0, rsp_result 0, busy 0, timeout_err 0. Reset mid-burst drops lock and all in-flight tags; no response issued for them.
- Back-to-back bursts from different requesters permitted; the resource pipeline keeps results ordered, so no stall needed.

## Timing
- Single-beat burst accepted at cycle t: mult_valid at t+1, mult_result sampled at t+1+LATENCY, rsp_valid at t+2+LATENCY.
- Multi-beat burst: response LATENCY+2 cycles after acceptance of the last beat.
- Arbitration decision and acceptance in the same cycle; new grant possible in the cycle after a last beat.
- busy = (state==LOCKED) | any tag valid | mult_valid.

## Configuration
- MULT_ADD_SCHED_TIMEOUT_EN defined: in LOCKED, counter increments each cycle owner req_valid is low, clears on accepted beat. On reaching TIMEOUT: -> IDLE, pointer = owner+1, timeout_err=1 for one cycle, no response for that burst (partial accumulation discarded; next burst reloads via sload). Counter 0 on reset and on entry to LOCKED.
- Not defined: no counter; LOCKED holds indefinitely; timeout_err tied 0.

## Test plan
- Reset, LATENCY=3, requester 1 sends single beat a=3,b=5,last -> mult_accum_sload=1, rsp_valid=4'b0010 with rsp_result=15 exactly 5 cycles after acceptance.
- Requester 0 burst (2,3),(4,5),(−1·… skip) (6,7) last -> sload only on beat 1, single rsp to 0 with result 6+20+42=68.
- All four req_valid held with single-beat bursts -> grants 0,1,2,3,0 in consecutive cycles, one rsp each, in order.
- Requester 2 locked mid-burst while 0 and 3 request -> req_ready stays 4'b0100 (or 0 in gaps) until last; next grant goes to 3.
- With MULT_ADD_SCHED_TIMEOUT_EN, TIMEOUT=64: owner stalls 64 cycles -> timeout_err pulse, IDLE, no rsp; without macro -> still LOCKED after 200 cycles.
- sclr_n low one cycle during in-flight burst -> no rsp_valid afterwards, busy=0, next grant from requester 0.

Source files
------------

// File: rtl/mult_add_sched.sv
// mult_add_sched: round-robin scheduler that time-shares one pipelined
// multiply-accumulate resource among NUM_REQ requesters, one burst at a time.
// A granted requester owns the resource until its last beat; the first beat of
// every burst loads the accumulator, and the final sum is routed back to the
// owner LATENCY+2 cycles after its last beat is accepted.
// Optional feature: define MULT_ADD_SCHED_TIMEOUT_EN to force-release a locked
// burst after TIMEOUT consecutive idle cycles from the owner (timeout_err pulse).
module mult_add_sched #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH_A      = 16,
    parameter int WIDTH_B      = 16,
    parameter int WIDTH_RESULT = 40,
    parameter int LATENCY      = 3,
    parameter int TIMEOUT      = 64
) (
    input  logic                       clock0,
    input  logic                       sclr_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*WIDTH_A-1:0] req_dataa,
    input  logic [NUM_REQ*WIDTH_B-1:0] req_datab,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [WIDTH_A-1:0]         mult_dataa,
    output logic [WIDTH_B-1:0]         mult_datab,
    output logic                       mult_valid,
    output logic                       mult_accum_sload,
    input  logic [WIDTH_RESULT-1:0]    mult_result,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [WIDTH_RESULT-1:0]    rsp_result,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Reject configurations the arbitration and tag pipe are not built for.
    if (NUM_REQ < 2 || NUM_REQ > 8 || LATENCY < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("mult_add_sched: unsupported parameter set");
    end

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    // One tag per issued beat, travelling alongside the resource pipeline.
    typedef struct packed {
        logic            valid;
        logic            last;
        logic [ID_W-1:0] id;
    } tag_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] ptr, ptr_nxt;
    logic [ID_W-1:0] owner, owner_nxt;
    logic [ID_W-1:0] grant;
    logic            grant_found;
    logic [ID_W-1:0] accept_id;
    logic            accept;
    logic            accept_last;
    logic [WIDTH_A-1:0] sel_a;
    logic [WIDTH_B-1:0] sel_b;
    tag_t            tag_pipe [0:LATENCY];
`ifdef MULT_ADD_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] idle_cnt;
    logic             timeout_hit;
`endif

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] p);
        return (p == ID_W'(NUM_REQ - 1)) ? '0 : p + ID_W'(1);
    endfunction

    // Round-robin search: first valid requester at or above the pointer, with wrap.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        logic [ID_W:0] sum;
        grant       = '0;
        grant_found = 1'b0;
        sum         = '0;
        // Walk from the farthest candidate down so the nearest valid one wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (sum >= (ID_W + 1)'(NUM_REQ)) begin
                sum = sum - (ID_W + 1)'(NUM_REQ);
            end
            if (req_valid[sum[ID_W-1:0]]) begin
                grant       = sum[ID_W-1:0];
                grant_found = 1'b1;
            end
        end
    end

    // Beat acceptance: only the grantee (IDLE) or the owner (LOCKED) sees ready.
    always_comb begin
        req_ready = '0;
        accept_id = (state == IDLE) ? grant : owner;
        if (sclr_n) begin
            if (state == IDLE) begin
                if (grant_found) begin
                    req_ready[grant] = 1'b1;
                end
            end else begin
                req_ready[owner] = req_valid[owner];
            end
        end
        accept = |req_ready;
    end

    // Operand and last-flag select for the accepted requester.
    always_comb begin
        sel_a       = '0;
        sel_b       = '0;
        accept_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept_id == ID_W'(i)) begin
                sel_a       = req_dataa[i*WIDTH_A +: WIDTH_A];
                sel_b       = req_datab[i*WIDTH_B +: WIDTH_B];
                accept_last = req_last[i];
            end
        end
    end

    // Next-state logic: lock on a non-last beat, release on last beat or timeout.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
`ifdef MULT_ADD_SCHED_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    if (accept_last) begin
                        ptr_nxt = next_ptr(grant);
                    end else begin
                        state_nxt = LOCKED;
                        owner_nxt = grant;
                    end
                end
            end
            LOCKED: begin
                if (accept && accept_last) begin
                    state_nxt = IDLE;
                    ptr_nxt   = next_ptr(owner);
                end
`ifdef MULT_ADD_SCHED_TIMEOUT_EN
                else if (!req_valid[owner] && idle_cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt   = IDLE;
                    ptr_nxt     = next_ptr(owner);
                    timeout_hit = 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clock0) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!sclr_n) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
        end
    end

    // Issue register: operands and sload hold between beats.
    always_ff @(posedge clock0) begin
        if (!sclr_n) begin
            mult_dataa       <= '0;
            mult_datab       <= '0;
            mult_accum_sload <= 1'b0;
        end else if (accept) begin
            mult_dataa       <= sel_a;
            mult_datab       <= sel_b;
            mult_accum_sload <= (state == IDLE);
        end
    end

    // Tag pipe aligned with the resource: stage 0 matches mult_valid, stage LATENCY matches mult_result.
    always_ff @(posedge clock0) begin
        if (!sclr_n) begin
            // NOTE: the tag pipe is a handful of flops, so it is reset outright; that is what drops in-flight responses.
            for (int s = 0; s <= LATENCY; s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{valid: accept, last: accept & accept_last, id: accept_id};
            for (int s = 1; s <= LATENCY; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    assign mult_valid = tag_pipe[0].valid;

    // Response capture: route the accumulated sum of a finished burst to its owner.
    always_ff @(posedge clock0) begin
        if (!sclr_n) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
        end else if (tag_pipe[LATENCY].valid && tag_pipe[LATENCY].last) begin
            rsp_valid  <= NUM_REQ'(1) << tag_pipe[LATENCY].id;
            rsp_result <= mult_result;
        end else begin
            rsp_valid  <= '0;
        end
    end

    // Busy while a burst is locked or any beat is still inside the resource.
    always_comb begin
        busy = (state == LOCKED);
        for (int s = 0; s <= LATENCY; s++) begin
            busy = busy | tag_pipe[s].valid;
        end
    end

`ifdef MULT_ADD_SCHED_TIMEOUT_EN
    // Idle-beat counter for the locked owner; cleared outside LOCKED and on every accepted beat.
    always_ff @(posedge clock0) begin
        if (!sclr_n || state != LOCKED || accept) begin
            idle_cnt <= '0;
        end else if (!req_valid[owner]) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end

    // One-cycle error pulse on forced release.
    always_ff @(posedge clock0) begin
        if (!sclr_n) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_add_sched.sv
// tb_mult_add_sched: self-checking bench for mult_add_sched. A behavioural
// multiply-accumulate resource drives mult_result; a reference model built from
// the scheduling rules (round robin, burst lock, per-burst sums, fixed response
// delay) predicts req_ready, issue, busy and responses every cycle.
// Build with +define+MULT_ADD_SCHED_TIMEOUT_EN to exercise the timeout release.
module tb_mult_add_sched;

    localparam int N   = 4;
    localparam int WA  = 16;
    localparam int WB  = 16;
    localparam int WR  = 40;
    localparam int LAT = 3;
    localparam int TO  = 64;

    logic            clock0;
    logic            sclr_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*WA-1:0] req_dataa;
    logic [N*WB-1:0] req_datab;
    logic [N-1:0]    req_ready;
    logic [WA-1:0]   mult_dataa;
    logic [WB-1:0]   mult_datab;
    logic            mult_valid;
    logic            mult_accum_sload;
    logic [WR-1:0]   mult_result;
    logic [N-1:0]    rsp_valid;
    logic [WR-1:0]   rsp_result;
    logic            busy;
    logic            timeout_err;

    mult_add_sched #(
        .NUM_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB), .WIDTH_RESULT(WR),
        .LATENCY(LAT), .TIMEOUT(TO)
    ) dut (
        .clock0(clock0), .sclr_n(sclr_n),
        .req_valid(req_valid), .req_last(req_last),
        .req_dataa(req_dataa), .req_datab(req_datab), .req_ready(req_ready),
        .mult_dataa(mult_dataa), .mult_datab(mult_datab), .mult_valid(mult_valid),
        .mult_accum_sload(mult_accum_sload), .mult_result(mult_result),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial clock0 = 1'b0;
    always #5 clock0 = ~clock0;

    // Shared multiply-add resource: accumulator with synchronous load, LAT cycles to output.
    logic [WR-1:0] res_acc;
    logic [WR-1:0] res_pipe [LAT];
    always @(posedge clock0) begin
        logic [WR-1:0] nxt;
        nxt = res_acc;
        if (mult_valid === 1'b1) begin
            nxt = mult_accum_sload ? WR'(mult_dataa) * WR'(mult_datab)
                                   : res_acc + WR'(mult_dataa) * WR'(mult_datab);
        end
        res_acc     <= nxt;
        res_pipe[0] <= nxt;
        for (int k = 1; k < LAT; k++) res_pipe[k] <= res_pipe[k-1];
    end
    assign mult_result = res_pipe[LAT-1];

    // Checking bookkeeping.
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model state.
    typedef struct {
        int            id;
        logic [WR-1:0] res;
        int            due;
    } exp_rsp_t;

    exp_rsp_t      rsp_q[$];
    int            m_ptr, m_owner, m_idle;
    bit            m_locked;
    logic [WR-1:0] m_sum [N];
    int            cycle;
    int            last_acc;
    bit            exp_mv, exp_sload, exp_to;
    logic [WA-1:0] exp_a;
    logic [WB-1:0] exp_b;

    // Observations used by the directed scenarios.
    int            last_rsp_cycle;
    logic [WR-1:0] last_rsp_val;
    logic [N-1:0]  last_rsp_vec;
    logic [N-1:0]  last_ready;
    int            to_pulses;

    logic [WA-1:0] da [N];
    logic [WB-1:0] db [N];

    task automatic model_reset();
        rsp_q.delete();
        m_ptr    = 0;
        m_owner  = 0;
        m_idle   = 0;
        m_locked = 0;
        last_acc = -100;
        exp_mv   = 0;
        exp_to   = 0;
    endtask

    // Compare every registered output of the current cycle with the model.
    task automatic check_outputs();
        logic [N-1:0] exp_rv;
        bit           busy_exp;
        exp_rv = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cycle) begin
            exp_rv = N'(1) << rsp_q[0].id;
            check("rsp_result", rsp_result, rsp_q[0].res);
            void'(rsp_q.pop_front());
        end
        check("rsp_valid", rsp_valid, exp_rv);
        check("mult_valid", mult_valid, exp_mv);
        if (exp_mv) begin
            check("mult_sload", mult_accum_sload, exp_sload);
            check("mult_dataa", mult_dataa, exp_a);
            check("mult_datab", mult_datab, exp_b);
        end
        busy_exp = m_locked || (cycle - last_acc >= 1 && cycle - last_acc <= LAT + 1);
        check("busy", busy, busy_exp);
        check("timeout_err", timeout_err, exp_to);
        if (rsp_valid !== '0) begin
            last_rsp_cycle = cycle;
            last_rsp_val   = rsp_result;
            last_rsp_vec   = rsp_valid;
        end
        if (timeout_err === 1'b1) to_pulses++;
    endtask

    // One clock cycle: check outputs, drive inputs, check ready, advance the model.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input bit rst);
        logic [N-1:0]  exp_ready;
        logic [WR-1:0] prod;
        int            id;
        check_outputs();
        req_valid = v;
        req_last  = l;
        sclr_n    = !rst;
        for (int i = 0; i < N; i++) begin
            req_dataa[i*WA +: WA] = da[i];
            req_datab[i*WB +: WB] = db[i];
        end
        #1;
        exp_ready = '0;
        id        = -1;
        if (!rst) begin
            if (m_locked) begin
                if (v[m_owner]) id = m_owner;
            end else begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (v[(m_ptr + k) % N]) id = (m_ptr + k) % N;
                end
            end
            if (id >= 0) exp_ready = N'(1) << id;
        end
        check("req_ready", req_ready, exp_ready);
        last_ready = req_ready;
        exp_mv = 0;
        exp_to = 0;
        if (rst) begin
            model_reset();
        end else if (id >= 0) begin
            prod      = WR'(da[id]) * WR'(db[id]);
            m_sum[id] = m_locked ? m_sum[id] + prod : prod;
            exp_mv    = 1;
            exp_sload = !m_locked;
            exp_a     = da[id];
            exp_b     = db[id];
            last_acc  = cycle;
            m_idle    = 0;
            if (l[id]) begin
                rsp_q.push_back('{id: id, res: m_sum[id], due: cycle + LAT + 2});
                m_locked = 0;
                m_ptr    = (id + 1) % N;
            end else begin
                m_locked = 1;
                m_owner  = id;
            end
        end else if (m_locked) begin
`ifdef MULT_ADD_SCHED_TIMEOUT_EN
            m_idle++;
            if (m_idle == TO) begin
                m_locked = 0;
                m_ptr    = (m_owner + 1) % N;
                exp_to   = 1;
                m_idle   = 0;
            end
`endif
        end
        @(negedge clock0);
        cycle++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 0);
    endtask

    int t_acc;

    initial begin
        sclr_n    = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_dataa = '0;
        req_datab = '0;
        for (int i = 0; i < N; i++) begin
            da[i] = '0;
            db[i] = '0;
        end
        to_pulses      = 0;
        last_rsp_cycle = -1;
        last_rsp_val   = '0;
        last_rsp_vec   = '0;
        cycle          = 0;
        model_reset();
        repeat (2) @(negedge clock0);

        // Reset state, and ready stays low while reset is held.
        req_valid = '1;
        #1;
        check("reset_ready", req_ready, '0);
        check("reset_mult_valid", mult_valid, 1'b0);
        check("reset_dataa", mult_dataa, '0);
        check("reset_sload", mult_accum_sload, 1'b0);
        check("reset_rsp_valid", rsp_valid, '0);
        check("reset_rsp_result", rsp_result, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_timeout", timeout_err, 1'b0);
        req_valid = '0;
        @(negedge clock0);

        // Single beat from requester 1: 3*5 arrives LAT+2 cycles later.
        da[1] = 16'd3; db[1] = 16'd5;
        t_acc = cycle;
        step(4'b0010, 4'b0010, 0);
        idle(7);
        check("single_latency", 64'(last_rsp_cycle - t_acc), 64'(LAT + 2));
        check("single_result", last_rsp_val, 15);
        check("single_owner", last_rsp_vec, 4'b0010);

        // Three-beat burst from requester 0, with a gap in the middle.
        da[0] = 16'd2; db[0] = 16'd3; step(4'b0001, 4'b0000, 0);
        da[0] = 16'd4; db[0] = 16'd5; step(4'b0001, 4'b0000, 0);
        step(4'b0000, 4'b0000, 0);
        da[0] = 16'd6; db[0] = 16'd7; step(4'b0001, 4'b0001, 0);
        idle(7);
        check("burst_result", last_rsp_val, 68);
        check("burst_owner", last_rsp_vec, 4'b0001);

        // Round robin from a fresh reset with everybody requesting single beats.
        step('0, '0, 1);
        for (int i = 0; i < N; i++) begin
            da[i] = 16'(10 + i); db[i] = 16'(i + 1);
        end
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b1111, 0);
            check("rr_grant", last_ready, N'(1) << (k % N));
        end
        idle(7);
        check("rr_last_result", last_rsp_val, 10);

        // Requester 2 holds the lock while 0 and 3 keep requesting; 3 is granted next.
        step(4'b0100, 4'b0000, 0);
        step(4'b1101, 4'b0000, 0);
        check("lock_ready", last_ready, 4'b0100);
        step(4'b1001, 4'b0000, 0);
        check("lock_gap_ready", last_ready, 4'b0000);
        step(4'b1101, 4'b0100, 0);
        step(4'b1001, 4'b1001, 0);
        check("after_lock_grant", last_ready, 4'b1000);
        idle(7);

        // Owner stalls for a long time while others request.
        step(4'b0010, 4'b0000, 0);
        for (int i = 0; i < 200; i++) step(4'b1101, 4'b0000, 0);
`ifdef MULT_ADD_SCHED_TIMEOUT_EN
        check("timeout_pulses", to_pulses, 1);
`else
        check("no_timeout_busy", busy, 1'b1);
        check("no_timeout_pulses", to_pulses, 0);
`endif
        step(4'b0010, 4'b0010, 0);
        idle(7);

        // Reset while a finished burst and a locked burst are in flight.
        step(4'b1000, 4'b1000, 0);
        step(4'b0100, 4'b0000, 0);
        step('0, '0, 1);
        check("post_reset_busy", busy, 1'b0);
        idle(7);
        step(4'b1111, 4'b1111, 0);
        check("post_reset_grant", last_ready, 4'b0001);
        idle(7);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            for (int r = 0; r < N; r++) begin
                da[r] = WA'($urandom);
                db[r] = WB'($urandom);
            end
            step(N'($urandom_range(0, 15)),
                 N'($urandom_range(0, 15) & $urandom_range(0, 15)),
                 ($urandom_range(0, 299) == 0));
        end
        idle(LAT + 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
